// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall control slice.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } state_t;

  localparam int MEM_TIMEOUT_DEF  = 64;
  localparam int DRAIN_CYCLES_DEF = 4;

  // Register x0 is hard-wired to zero and never creates a dependency.
  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: the ID instruction needs a value that
// the load currently in EX has not produced yet.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       hazard
);

  // Match either used source against a non-x0 load destination.
  always_comb begin
    hazard = ex_memread && (ex_rd != REG_X0) &&
             ((id_uses_rs1 && (ex_rd == id_rs1)) ||
              (id_uses_rs2 && (ex_rd == id_rs2)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// branch redirects, data-memory freezes, debug halt/drain and timeout trap.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_stall,
  output logic             pc_redirect_en,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_bubble,
  output logic             halt_ack,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MEM_TIMEOUT - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [DW-1:0] drain_cnt;
  logic          mem_stall;
  logic          load_use_raw;
  logic          load_use;
  logic          drain_mode;
  logic          timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  load_use_detect u_load_use (
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .hazard      (load_use_raw)
  );

  // Hazard terms; a taken branch squashes the dependent ID instruction anyway.
  always_comb begin
    mem_stall  = mem_req && !mem_ready;
    load_use   = load_use_raw && !ex_branch_taken;
    drain_mode = (state == DRAIN);
    timeout    = mem_stall && (wait_cnt == WAIT_LAST);
  end

  // Zero-latency control decode from state and current hazards.
  always_comb begin
    pc_stall       = 1'b0;
    pc_redirect_en = 1'b0;
    ifid_stall     = 1'b0;
    ifid_flush     = 1'b0;
    idex_stall     = 1'b0;
    idex_flush     = 1'b0;
    exmem_stall    = 1'b0;
    memwb_bubble   = 1'b0;
    halt_ack       = 1'b0;
    mem_err        = 1'b0;
    if (!rst) begin
      case (state)
        RUN, DRAIN: begin
          if (mem_stall) begin
            // EX is frozen, so any pending redirect simply waits.
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_stall  = 1'b1;
            memwb_bubble = 1'b1;
          end else if (ex_branch_taken) begin
            pc_redirect_en = 1'b1;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            pc_stall       = drain_mode;
          end else if (load_use) begin
            // While draining, IF/ID is flushed instead of held.
            pc_stall   = 1'b1;
            idex_flush = 1'b1;
            ifid_stall = !drain_mode;
            ifid_flush = drain_mode;
          end else begin
            pc_stall   = drain_mode;
            ifid_flush = drain_mode;
          end
        end
        HALTED: begin
          pc_stall   = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          halt_ack   = 1'b1;
        end
        default: begin
          pc_stall     = 1'b1;
          ifid_stall   = 1'b1;
          idex_stall   = 1'b1;
          exmem_stall  = 1'b1;
          memwb_bubble = 1'b1;
          mem_err      = 1'b1;
        end
      endcase
    end
  end

  // Halt/drain/error FSM with wait, drain and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!mem_stall)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_LAST)
        wait_cnt <= wait_cnt + 1'b1;

      if (((state == RUN) || (state == DRAIN)) && (pc_stall || exmem_stall))
        stall_cnt <= sat_inc(stall_cnt);
      if (pc_redirect_en)
        flush_cnt <= sat_inc(flush_cnt);

      case (state)
        RUN: begin
          if (timeout) begin
            state <= ERROR;
          end else if (halt_req) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (timeout)
            state <= ERROR;
          else if (!halt_req)
            state <= RUN;
          else if (!mem_stall) begin
            if (ex_branch_taken)
              drain_cnt <= '0;
            else if (drain_cnt == DRAIN_LAST)
              state <= HALTED;
            else
              drain_cnt <= drain_cnt + 1'b1;
          end
        end
        HALTED: begin
          if (timeout)
            state <= ERROR;
          else if (!halt_req)
            state <= RUN;
        end
        default: state <= ERROR;
      endcase
    end
  end

endmodule
